// File: rtl/br_pkg.sv
// Shared opcode classes, condition codes and branch-FSM state encoding.
// Pure definitions: no latency, no backpressure.
package br_pkg;

  localparam logic [2:0] OPC_BR  = 3'b011;
  localparam logic [2:0] OPC_JMP = 3'b001;

  localparam logic [1:0] CC_EQZ = 2'b00;
  localparam logic [1:0] CC_NEZ = 2'b01;
  localparam logic [1:0] CC_LTZ = 2'b10;
  localparam logic [1:0] CC_GEZ = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    SQUASH  = 2'd2
  } br_state_t;

  // Register-indirect jumps and all conditional branches read rs.
  function automatic logic needs_rs(input logic [4:0] opc);
    return (opc[4:2] == OPC_BR) || ((opc[4:2] == OPC_JMP) && opc[0]);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Taken/not-taken decision for one control opcode and its rs operand; purely combinational.
// No backpressure: the caller decides when the result is used.
module br_cond_eval
  import br_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        i_opc,
  input  logic [DATA_W-1:0] i_operand,
  output logic              o_taken
);

  always_comb begin
    o_taken = 1'b0;
    if (i_opc[4:2] == OPC_JMP) begin
      o_taken = 1'b1;
    end else if (i_opc[4:2] == OPC_BR) begin
      case (i_opc[1:0])
        CC_EQZ:  o_taken = (i_operand == '0);
        CC_NEZ:  o_taken = (i_operand != '0);
        CC_LTZ:  o_taken = i_operand[DATA_W-1];
        CC_GEZ:  o_taken = !i_operand[DATA_W-1];
        default: o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: redirect/squash one cycle after resolution, +1 cycle on load-use.
// pipe_stall freezes decisions; id_stall holds PC and IF/ID for the load-use bubble.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [4:0]           id_instr,
  input  logic [REG_IDX_W-1:0] id_rs_idx,
  input  logic [DATA_W-1:0]    id_rs_data,
  input  logic [DATA_W-1:0]    id_target,
  input  logic                 ex_wr_en,
  input  logic [REG_IDX_W-1:0] ex_wr_idx,
  input  logic                 ex_is_load,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic                 mem_wr_en,
  input  logic [REG_IDX_W-1:0] mem_wr_idx,
  input  logic [DATA_W-1:0]    mem_result,
  input  logic                 pipe_stall,
  output logic                 id_stall,
  output logic                 pc_redirect,
  output logic [DATA_W-1:0]    pc_target,
  output logic                 squash_id,
  output logic [CNT_W-1:0]     br_total_cnt,
  output logic [CNT_W-1:0]     br_taken_cnt
);

  br_state_t         r_state, w_state_nxt;
  logic              w_is_ctrl, w_needs_rs, w_ex_fwd, w_mem_fwd, w_load_use;
  logic              w_resolve, w_taken, w_take;
  logic [DATA_W-1:0] w_operand;
  logic              r_pc_redirect, r_squash;
  logic [DATA_W-1:0] r_pc_target;
  logic [CNT_W-1:0]  r_total, r_taken;

  assign w_is_ctrl  = (id_instr[4:2] == OPC_BR) || (id_instr[4:2] == OPC_JMP);
  assign w_needs_rs = needs_rs(id_instr);
  assign w_ex_fwd   = ex_wr_en && (ex_wr_idx == id_rs_idx) && !ex_is_load;
  assign w_mem_fwd  = mem_wr_en && (mem_wr_idx == id_rs_idx);
  assign w_load_use = w_needs_rs && ex_wr_en && (ex_wr_idx == id_rs_idx) && ex_is_load;

  // After a load-use bubble the load sits in MEM, so its data is the operand.
  always_comb begin
    w_operand = id_rs_data;
    if (r_state == LD_WAIT) w_operand = mem_result;
    else if (w_ex_fwd)      w_operand = ex_result;
    else if (w_mem_fwd)     w_operand = mem_result;
  end

  br_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .i_opc     (id_instr),
    .i_operand (w_operand),
    .o_taken   (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (id_valid && w_is_ctrl && !pipe_stall) begin
          if (w_load_use)   w_state_nxt = LD_WAIT;
          else if (w_taken) w_state_nxt = SQUASH;
        end
      end
      LD_WAIT: begin
        if (!pipe_stall) w_state_nxt = w_taken ? SQUASH : IDLE;
      end
      SQUASH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    id_stall  = 1'b0;
    w_resolve = 1'b0;
    case (r_state)
      IDLE: begin
        if (id_valid && w_is_ctrl && !pipe_stall) begin
          id_stall  = w_load_use;
          w_resolve = !w_load_use;
        end
      end
      LD_WAIT: w_resolve = !pipe_stall;
      default: ;
    endcase
  end

  assign w_take = w_resolve && w_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_redirect <= 1'b0;
      r_squash      <= 1'b0;
      r_pc_target   <= '0;
    end else begin
      r_pc_redirect <= w_take;
      r_squash      <= w_take;
      if (w_take) r_pc_target <= id_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
      r_taken <= '0;
    end else begin
      if (w_resolve && (r_total != '1)) r_total <= r_total + CNT_W'(1);
      if (w_take && (r_taken != '1))    r_taken <= r_taken + CNT_W'(1);
    end
  end

  assign pc_redirect  = r_pc_redirect;
  assign squash_id    = r_squash;
  assign pc_target    = r_pc_target;
  assign br_total_cnt = r_total;
  assign br_taken_cnt = r_taken;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_instr;
  logic [2:0]  id_rs_idx;
  logic [15:0] id_rs_data, id_target;
  logic        ex_wr_en, ex_is_load;
  logic [2:0]  ex_wr_idx;
  logic [15:0] ex_result;
  logic        mem_wr_en;
  logic [2:0]  mem_wr_idx;
  logic [15:0] mem_result;
  logic        pipe_stall;

  logic        id_stall, pc_redirect, squash_id;
  logic [15:0] pc_target, br_total_cnt, br_taken_cnt;
  logic        s_id_stall, s_pc_redirect, s_squash_id;
  logic [15:0] s_pc_target;
  logic [3:0]  s_total, s_taken;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_idx(id_rs_idx), .id_rs_data(id_rs_data), .id_target(id_target),
    .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx),
    .mem_result(mem_result), .pipe_stall(pipe_stall), .id_stall(id_stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .squash_id(squash_id),
    .br_total_cnt(br_total_cnt), .br_taken_cnt(br_taken_cnt)
  );

  branch_ctrl #(.CNT_W(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_idx(id_rs_idx), .id_rs_data(id_rs_data), .id_target(id_target),
    .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx),
    .mem_result(mem_result), .pipe_stall(pipe_stall), .id_stall(s_id_stall),
    .pc_redirect(s_pc_redirect), .pc_target(s_pc_target), .squash_id(s_squash_id),
    .br_total_cnt(s_total), .br_taken_cnt(s_taken)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_instr = 5'b00000; id_rs_idx = 0; id_rs_data = 0; id_target = 0;
    ex_wr_en = 0; ex_wr_idx = 0; ex_is_load = 0; ex_result = 0;
    mem_wr_en = 0; mem_wr_idx = 0; mem_result = 0; pipe_stall = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // Reference decision taken straight from the opcode/condition table.
  function automatic bit ref_taken(input bit [4:0] op, input bit [15:0] v);
    if (op[4:2] == 3'b001) return 1'b1;
    case (op[1:0])
      2'd0: return v == 16'd0;
      2'd1: return v != 16'd0;
      2'd2: return v[15] == 1'b1;
      default: return v[15] == 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    n_chk++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect got=%b exp=0", pc_redirect); end
    n_chk++; if (squash_id !== 1'b0) begin n_bad++; $display("FAIL reset_squash got=%b exp=0", squash_id); end
    n_chk++; if (pc_target !== 16'h0) begin n_bad++; $display("FAIL reset_target got=%h exp=0000", pc_target); end
    n_chk++; if (br_total_cnt !== 16'h0 || br_taken_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", br_total_cnt, br_taken_cnt); end
    n_chk++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_beqz_taken();
    do_reset();
    id_valid = 1; id_instr = 5'b01100; id_rs_idx = 2; id_rs_data = 16'h0000; id_target = 16'h0040;
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL beqz_stall got=%b exp=0", id_stall); end
    tick();
    clear_inputs();
    n_chk++; if (pc_redirect !== 1'b1 || squash_id !== 1'b1) begin n_bad++; $display("FAIL beqz_pulse got=%b%b exp=11", pc_redirect, squash_id); end
    n_chk++; if (pc_target !== 16'h0040) begin n_bad++; $display("FAIL beqz_target got=%h exp=0040", pc_target); end
    n_chk++; if (br_total_cnt !== 16'd1 || br_taken_cnt !== 16'd1) begin n_bad++; $display("FAIL beqz_cnt got=%0d/%0d exp=1/1", br_total_cnt, br_taken_cnt); end
    tick();
    n_chk++; if (pc_redirect !== 1'b0 || squash_id !== 1'b0) begin n_bad++; $display("FAIL beqz_single_pulse got=%b%b exp=00", pc_redirect, squash_id); end
  endtask

  task automatic test_bnez_forward();
    do_reset();
    id_valid = 1; id_instr = 5'b01101; id_rs_idx = 5; id_rs_data = 16'h1234; id_target = 16'h0100;
    ex_wr_en = 1; ex_wr_idx = 5; ex_is_load = 0; ex_result = 16'h0000;
    mem_wr_en = 1; mem_wr_idx = 5; mem_result = 16'h5555;
    tick();
    clear_inputs();
    n_chk++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL bnez_fwd_redirect got=%b exp=0", pc_redirect); end
    n_chk++; if (br_total_cnt !== 16'd1 || br_taken_cnt !== 16'd0) begin n_bad++; $display("FAIL bnez_fwd_cnt got=%0d/%0d exp=1/0", br_total_cnt, br_taken_cnt); end
  endtask

  task automatic test_load_use();
    int stall_cycles = 0;
    do_reset();
    id_valid = 1; id_instr = 5'b01110; id_rs_idx = 3; id_rs_data = 16'h0000; id_target = 16'h0abc;
    ex_wr_en = 1; ex_wr_idx = 3; ex_is_load = 1;
    #1;
    if (id_stall === 1'b1) stall_cycles++;
    tick();
    n_chk++; if (pc_redirect !== 1'b0 || br_total_cnt !== 16'd0) begin n_bad++; $display("FAIL ld_no_decision got=%b/%0d exp=0/0", pc_redirect, br_total_cnt); end
    ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_idx = 3; mem_result = 16'h8000;
    #1;
    if (id_stall === 1'b1) stall_cycles++;
    n_chk++; if (stall_cycles != 1) begin n_bad++; $display("FAIL ld_stall_cycles got=%0d exp=1", stall_cycles); end
    tick();
    clear_inputs();
    n_chk++; if (pc_redirect !== 1'b1 || pc_target !== 16'h0abc) begin n_bad++; $display("FAIL ld_redirect got=%b/%h exp=1/0abc", pc_redirect, pc_target); end
    n_chk++; if (br_total_cnt !== 16'd1 || br_taken_cnt !== 16'd1) begin n_bad++; $display("FAIL ld_cnt got=%0d/%0d exp=1/1", br_total_cnt, br_taken_cnt); end
  endtask

  task automatic test_jump_pipe_stall();
    do_reset();
    id_valid = 1; id_instr = 5'b00101; id_rs_idx = 6; id_rs_data = 16'h7777; id_target = 16'h1234;
    pipe_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL jmp_hold_stall cyc=%0d got=%b exp=0", i, id_stall); end
      tick();
      n_chk++; if (pc_redirect !== 1'b0 || br_total_cnt !== 16'd0) begin n_bad++; $display("FAIL jmp_hold cyc=%0d got=%b/%0d exp=0/0", i, pc_redirect, br_total_cnt); end
    end
    pipe_stall = 0;
    tick();
    clear_inputs();
    n_chk++; if (pc_redirect !== 1'b1 || pc_target !== 16'h1234) begin n_bad++; $display("FAIL jmp_redirect got=%b/%h exp=1/1234", pc_redirect, pc_target); end
    n_chk++; if (br_total_cnt !== 16'd1 || br_taken_cnt !== 16'd1) begin n_bad++; $display("FAIL jmp_cnt got=%0d/%0d exp=1/1", br_total_cnt, br_taken_cnt); end
  endtask

  task automatic test_squash_ignore();
    do_reset();
    id_valid = 1; id_instr = 5'b01100; id_rs_data = 16'h0000; id_target = 16'h0080;
    tick();
    id_instr = 5'b00100; id_target = 16'h0200;
    tick();
    clear_inputs();
    n_chk++; if (pc_redirect !== 1'b0 || pc_target !== 16'h0080) begin n_bad++; $display("FAIL sq_ignore got=%b/%h exp=0/0080", pc_redirect, pc_target); end
    n_chk++; if (br_total_cnt !== 16'd1 || br_taken_cnt !== 16'd1) begin n_bad++; $display("FAIL sq_cnt got=%0d/%0d exp=1/1", br_total_cnt, br_taken_cnt); end
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    do_reset();
    id_valid = 1; id_instr = 5'b01100; id_rs_data = 16'h0000; id_target = 16'h0300;
    #1;
    rst_n = 0;
    tick();
    if (pc_redirect === 1'b1) seen = 1;
    rst_n = 1;
    clear_inputs();
    tick();
    if (pc_redirect === 1'b1) seen = 1;
    tick();
    if (pc_redirect === 1'b1) seen = 1;
    n_chk++; if (seen) begin n_bad++; $display("FAIL abort_redirect got=1 exp=0"); end
    n_chk++; if (br_total_cnt !== 16'd0 || br_taken_cnt !== 16'd0) begin n_bad++; $display("FAIL abort_cnt got=%0d/%0d exp=0/0", br_total_cnt, br_taken_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      id_valid = 1; id_instr = 5'b00100; id_target = 16'(i);
      tick();
      id_valid = 0;
      tick();
    end
    n_chk++; if (s_total !== 4'hF || s_taken !== 4'hF) begin n_bad++; $display("FAIL sat_small got=%h/%h exp=f/f", s_total, s_taken); end
    n_chk++; if (br_total_cnt !== 16'd20 || br_taken_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_wide got=%0d/%0d exp=20/20", br_total_cnt, br_taken_cnt); end
  endtask

  task automatic test_random();
    bit m_sq = 0, m_wait = 0, nwait, res, tk, exp_stall;
    int m_total = 0, m_taken = 0;
    logic [15:0] m_target = 0, opnd;
    logic [15:0] vals[4];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      vals[0] = 16'h0000; vals[1] = 16'h8000; vals[2] = 16'($urandom); vals[3] = 16'h0001;
      if (!m_wait) begin
        id_valid = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 3))
          0: id_instr = 5'($urandom);
          1, 2: id_instr = {3'b011, 2'($urandom)};
          default: id_instr = {3'b001, 2'($urandom)};
        endcase
        id_rs_idx = 3'($urandom_range(0, 3));
        id_rs_data = vals[$urandom_range(0, 3)];
        id_target = 16'($urandom);
      end
      ex_wr_en = $urandom_range(0, 1); ex_wr_idx = 3'($urandom_range(0, 3));
      ex_is_load = ($urandom_range(0, 2) == 0); ex_result = vals[$urandom_range(0, 3)];
      mem_wr_en = $urandom_range(0, 1); mem_wr_idx = 3'($urandom_range(0, 3));
      mem_result = vals[$urandom_range(0, 3)];
      pipe_stall = ($urandom_range(0, 4) == 0);

      exp_stall = 0; res = 0; nwait = m_wait; opnd = id_rs_data;
      if (m_sq) begin
      end else if (pipe_stall) begin
      end else if (m_wait) begin
        res = 1; opnd = mem_result;
      end else if (id_valid && (id_instr[4:2] == 3'b011 || id_instr[4:2] == 3'b001)) begin
        if ((id_instr[4:2] == 3'b011 || id_instr[0]) && ex_wr_en && ex_wr_idx == id_rs_idx && ex_is_load) begin
          exp_stall = 1; nwait = 1;
        end else begin
          res = 1;
          if (ex_wr_en && ex_wr_idx == id_rs_idx && !ex_is_load) opnd = ex_result;
          else if (mem_wr_en && mem_wr_idx == id_rs_idx) opnd = mem_result;
        end
      end
      tk = res && ref_taken(id_instr, opnd);
      if (res) begin
        m_total++; nwait = 0;
        if (tk) begin m_taken++; m_target = id_target; end
      end
      #1;
      n_chk++; if (id_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, id_stall, exp_stall); end
      tick();
      m_sq = tk; m_wait = nwait;
      n_chk++; if (pc_redirect !== m_sq || squash_id !== m_sq) begin n_bad++; $display("FAIL rnd_pulse cyc=%0d got=%b%b exp=%b", c, pc_redirect, squash_id, m_sq); end
      n_chk++; if (pc_target !== m_target) begin n_bad++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", c, pc_target, m_target); end
      n_chk++; if (br_total_cnt !== 16'(m_total) || br_taken_cnt !== 16'(m_taken)) begin n_bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, br_total_cnt, br_taken_cnt, m_total, m_taken); end
      n_chk++; if (s_total !== 4'((m_total > 15) ? 15 : m_total) || s_taken !== 4'((m_taken > 15) ? 15 : m_taken)) begin n_bad++; $display("FAIL rnd_sat cyc=%0d got=%0d/%0d exp=%0d/%0d", c, s_total, s_taken, m_total, m_taken); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_beqz_taken();
    test_bnez_forward();
    test_load_use();
    test_jump_pipe_stall();
    test_squash_ignore();
    test_reset_abort();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequences control-flow resolution in the decode (ID) stage of the 16-bit pipelined core.
- Classifies the ID-stage opcode and picks the rs operand from forwarding or the register file.
- Evaluates the branch condition and stalls on load-use hazards.
- Issues a registered PC redirect plus a one-cycle squash of the wrong-path instruction.
- Keeps saturating branch statistics for the perf counters.

Parameters:
DATA_W, 16, operand/PC width
REG_IDX_W, 3, register index width
CNT_W, 16, statistics counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a live instruction
id_instr  input  5  opcode bits [15:11] of the ID instruction
id_rs_idx  input  REG_IDX_W  rs index of the ID instruction
id_rs_data  input  DATA_W  rs value from the register file
id_target  input  DATA_W  precomputed branch/jump target
ex_wr_en  input  1  EX instruction writes a register
ex_wr_idx  input  REG_IDX_W  EX destination index
ex_is_load  input  1  EX instruction is a load
ex_result  input  DATA_W  EX ALU result
mem_wr_en  input  1  MEM instruction writes a register
mem_wr_idx  input  REG_IDX_W  MEM destination index
mem_result  input  DATA_W  MEM result, including load data
pipe_stall  input  1  global pipeline hold (memory stall)
id_stall  output  1  hold PC and IF/ID this cycle (combinational)
pc_redirect  output  1  load pc_target into the PC (registered)
pc_target  output  DATA_W  redirect address (registered)
squash_id  output  1  convert the ID instruction to a NOP (registered)
br_total_cnt  output  CNT_W  resolved control instructions
br_taken_cnt  output  CNT_W  taken control instructions

Behaviour:
Reset:
- On rst_n low: state IDLE.
- pc_redirect, squash_id, pc_target, br_total_cnt and br_taken_cnt all go to 0.
- id_stall is 0.
- Reset asserted mid-sequence aborts any pending redirect.

Classification:
- instr[4:2]=011 is conditional; instr[1:0] selects 00 eqz, 01 nez, 10 ltz (bit15), 11 gez.
- instr[4:2]=001 is a jump, always taken. It needs rs only when instr[0]=1 (register-indirect).
- Anything else is a non-control instruction: no action, no count.

Operand select, in priority order:
1. ex_result, if ex_wr_en && ex_wr_idx==id_rs_idx && !ex_is_load.
2. mem_result, if mem_wr_en && mem_wr_idx==id_rs_idx.
3. id_rs_data otherwise.

States:
- IDLE, for a live control instruction in ID with pipe_stall=0:
  - Load-use hazard (needs rs && ex_wr_en && ex_wr_idx match && ex_is_load): id_stall=1 this cycle, go to LD_WAIT, no decision.
  - Otherwise resolve now. br_total_cnt increments.
  - If taken: br_taken_cnt increments; next cycle pc_redirect=1, pc_target=id_target, squash_id=1; go to SQUASH.
  - If not taken: stay in IDLE.
- LD_WAIT:
  - The load is now in MEM, so the operand comes from mem_result.
  - Resolve exactly as in IDLE (never re-stall).
  - Go to SQUASH if taken, otherwise IDLE.
- SQUASH:
  - Lasts one cycle. pc_redirect and squash_id are high during it.
  - id_valid is ignored (wrong-path instruction). Always return to IDLE.

Timing and boundaries:
- pc_redirect and squash_id are single-cycle pulses, low in every other state.
- pipe_stall=1 in IDLE or LD_WAIT: the state holds, there is no decision and no count, and id_stall=0. pipe_stall wins over a simultaneous decision.
- pipe_stall=1 in SQUASH does not stretch the pulse. The PC owner latches the redirect regardless.
- Counters saturate at all-ones and never wrap. br_taken_cnt never exceeds br_total_cnt.
- Redirect latency: 1 cycle after resolution, i.e. 1 cycle after entry with no hazard, 2 cycles with a load hazard.

Decomposition:
Shared package br_pkg holds:
- opcode class constants OPC_BR=3'b011 and OPC_JMP=3'b001;
- condition codes CC_EQZ, CC_NEZ, CC_LTZ, CC_GEZ;
- the state encoding IDLE/LD_WAIT/SQUASH.

One combinational sub-module, br_cond_eval (operand and opcode in, taken out), holds the condition logic. Forwarding mux, FSM and counters stay in branch_ctrl.

Test Plan:
1. Reset. Then beqz, rs register-file value 0x0000, no hazards, id_target=0x0040 → next cycle pc_redirect=1, pc_target=0x0040, squash_id=1. Counts total=1, taken=1.
2. bnez with ex_result=0x0000 forwarded (EX writes rs, non-load) while id_rs_data=0x1234 → EX value used, not taken, no redirect. Counts total=1, taken=0.
3. bltz, EX is a load to rs → id_stall=1 for exactly 1 cycle. In LD_WAIT mem_result=0x8000 → redirect the following cycle, with 2-cycle total latency.
4. Register-indirect jump (instr=00101) with pipe_stall=1 for 3 cycles → no decision, no count and no stall while held. Redirect 1 cycle after pipe_stall drops.
5. Taken branch followed by another branch in ID during SQUASH → the second is ignored. br_total_cnt advances by 1 only.
6. Assert rst_n=0 in the cycle between decision and redirect → pc_redirect never pulses. Counters read 0.
7. Preload near saturation (CNT_W=4), run 20 taken jumps → both counters hold at 0xF.
